// File: rtl/fft_host_sequencer.sv
// Host-side sequencer that streams 128 samples into an FFT ASIC over a register bus,
// polls device status per sample, fetches the tone result and handles error escape.
module fft_host_sequencer #(
  parameter int unsigned POLL_LIMIT = 1023,
  parameter int unsigned ADDR_MCU   = 3,
  parameter int unsigned ADDR_SMP   = 4,
  parameter int unsigned ADDR_ASIC  = 5,
  parameter int unsigned ADDR_RES   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        err_clear,
  output logic        smp_req,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  output logic        reg_req,
  output logic        reg_we,
  output logic [2:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  input  logic        reg_ack,
  input  logic        reg_nack,
  output logic        busy,
  output logic        done,
  output logic [15:0] tone,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  state_o
);

  localparam int unsigned CNT_W = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_EN       = 4'd1,
    S_FETCH    = 4'd2,
    S_WR_SMP   = 4'd3,
    S_WR_IDX   = 4'd4,
    S_POLL     = 4'd5,
    S_RES_POLL = 4'd6,
    S_RD_RES   = 4'd7,
    S_ACK      = 4'd8,
    S_CLR      = 4'd9,
    S_ERR      = 4'd10,
    S_ESC      = 4'd11,
    S_ESC_CLR  = 4'd12
  } state_t;

  state_t             state_q, state_n;
  logic [6:0]         idx_q, idx_n;
  logic [15:0]        smp_q, smp_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               req_n, we_n, smp_req_n, busy_n, done_n, error_n;
  logic [2:0]         addr_n;
  logic [15:0]        wdata_n, tone_n;
  logic [1:0]         code_n;

  logic               cmd_bus, cmd_we;
  logic [2:0]         cmd_addr;
  logic [15:0]        cmd_wdata;

  logic               bus_ok, bus_nack, poll_expired, dev_err, res_ready;
  logic [6:0]         idx_inc;

  // nack wins over a simultaneous ack
  assign bus_ok       = reg_req & reg_ack & ~reg_nack;
  assign bus_nack     = reg_req & reg_nack;
  assign idx_inc      = idx_q + 7'd1;
  assign dev_err      = (reg_rdata[6:3] == 4'd7);
  assign res_ready    = reg_rdata[0] & (reg_rdata[6:3] == 4'd6);
  assign poll_expired = (32'(cnt_q) + 32'd1) >= POLL_LIMIT;
  assign state_o      = state_q;

  // Bus command owned by each bus-facing state
  always_comb begin
    cmd_bus   = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 3'(ADDR_MCU);
    cmd_wdata = 16'h0000;
    case (state_q)
      S_EN:       cmd_wdata = 16'h0001;
      S_WR_SMP: begin
        cmd_addr  = 3'(ADDR_SMP);
        cmd_wdata = smp_q;
      end
      S_WR_IDX:   cmd_wdata = {1'b0, idx_q, 8'h03};
      S_POLL, S_RES_POLL: begin
        cmd_we   = 1'b0;
        cmd_addr = 3'(ADDR_ASIC);
      end
      S_RD_RES: begin
        cmd_we   = 1'b0;
        cmd_addr = 3'(ADDR_RES);
      end
      S_ACK:      cmd_wdata = 16'h0004;
      S_CLR:      cmd_wdata = 16'h0000;
      S_ESC:      cmd_wdata = 16'h0010;
      S_ESC_CLR:  cmd_wdata = 16'h0000;
      default:    cmd_bus = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    smp_n     = smp_q;
    cnt_n     = cnt_q;
    req_n     = reg_req;
    we_n      = reg_we;
    addr_n    = reg_addr;
    wdata_n   = reg_wdata;
    smp_req_n = 1'b0;
    done_n    = 1'b0;
    tone_n    = tone;
    error_n   = error;
    code_n    = err_code;

    // Issue one request per bus state; hold it until ack/nack, then drop it
    if (cmd_bus) begin
      if (!reg_req) begin
        req_n   = 1'b1;
        we_n    = cmd_we;
        addr_n  = cmd_addr;
        wdata_n = cmd_wdata;
      end else if (reg_ack || reg_nack) begin
        req_n = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        idx_n   = 7'd0;
        state_n = S_EN;
      end
      S_EN:     if (bus_ok) state_n = S_FETCH;
      S_FETCH: begin
        smp_req_n = 1'b1;
        if (smp_req && smp_valid) begin
          smp_req_n = 1'b0;
          smp_n     = smp_data;
          state_n   = S_WR_SMP;
        end
      end
      S_WR_SMP: if (bus_ok) state_n = S_WR_IDX;
      S_WR_IDX: if (bus_ok) state_n = S_POLL;
      S_POLL: if (bus_ok) begin
        if (dev_err) begin
          state_n = S_ERR;
          code_n  = 2'd2;
        end else if (reg_rdata[14:8] == idx_inc) begin
          if (idx_q == 7'd127) begin
            state_n = S_RES_POLL;
          end else begin
            idx_n   = idx_inc;
            state_n = S_FETCH;
          end
        end else if (poll_expired) begin
          state_n = S_ERR;
          code_n  = 2'd1;
        end else begin
          cnt_n = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_RES_POLL: if (bus_ok) begin
        if (dev_err) begin
          state_n = S_ERR;
          code_n  = 2'd2;
        end else if (res_ready) begin
          state_n = S_RD_RES;
        end else if (poll_expired) begin
          state_n = S_ERR;
          code_n  = 2'd1;
        end else begin
          cnt_n = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_RD_RES: if (bus_ok) begin
        tone_n  = reg_rdata;
        state_n = S_ACK;
      end
      S_ACK:    if (bus_ok) state_n = S_CLR;
      S_CLR: if (bus_ok) begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR:    if (err_clear) state_n = S_ESC;
      S_ESC:    if (bus_ok) state_n = S_ESC_CLR;
      S_ESC_CLR: if (bus_ok) begin
        error_n = 1'b0;
        code_n  = 2'd0;
        state_n = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase

    if (bus_nack) begin
      state_n = S_ERR;
      code_n  = 2'd3;
    end
    if (state_n == S_ERR) error_n = 1'b1;
    // Poll budget is per visit to a poll state
    if (state_n != state_q) cnt_n = '0;
    busy_n = (state_n != S_IDLE) && (state_n != S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 7'd0;
      smp_q     <= 16'h0000;
      cnt_q     <= '0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= 3'd0;
      reg_wdata <= 16'h0000;
      smp_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tone      <= 16'h0000;
      error     <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      smp_q     <= smp_n;
      cnt_q     <= cnt_n;
      reg_req   <= req_n;
      reg_we    <= we_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      smp_req   <= smp_req_n;
      busy      <= busy_n;
      done      <= done_n;
      tone      <= tone_n;
      error     <= error_n;
      err_code  <= code_n;
    end
  end

endmodule

// File: tb/tb_fft_host_sequencer.sv
// Self-checking bench: device/source model plus a write scoreboard for fft_host_sequencer.
module tb_fft_host_sequencer;

  localparam logic [2:0]  A_MCU  = 3'd3;
  localparam logic [2:0]  A_SMP  = 3'd4;
  localparam logic [2:0]  A_ASIC = 3'd5;
  localparam logic [15:0] RESULT = 16'h1234;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        err_clear = 1'b0;
  logic        smp_req;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_data = 16'h0000;
  logic        reg_req, reg_we;
  logic [2:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = 16'h0000;
  logic        reg_ack = 1'b0;
  logic        reg_nack = 1'b0;
  logic        busy, done, error;
  logic [15:0] tone;
  logic [1:0]  err_code;
  logic [3:0]  state_o;

  fft_host_sequencer #(.POLL_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .err_clear(err_clear),
    .smp_req(smp_req), .smp_valid(smp_valid), .smp_data(smp_data),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_nack(reg_nack),
    .busy(busy), .done(done), .tone(tone), .error(error), .err_code(err_code),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [18:0] sb_q[$];

  // device model state
  bit          in_flight = 0;
  int          lat = 0;
  logic        cur_we = 1'b0;
  logic [2:0]  cur_addr = 3'd0;
  logic [15:0] cur_wdata = 16'h0000;
  logic [6:0]  dev_idx = 7'd0;
  int          rd_cnt = 0;
  bit          matched = 0;
  int          err_at = -1;
  bit          stuck = 0;
  bit          nack_en = 0;
  // monitors
  int asic_reads = 0, fetch_n = 0, smp_hi = 0, smp_cycles = 0;
  int stall_idx = -1, stall_run = 0, bus_in_fetch = 0, done_cnt = 0;

  function automatic logic [15:0] sample_of(input int i);
    return 16'h4000 + 16'(i * 37);
  endfunction

  // Next-sample field echoes idx+1 on the third read; afterwards report result ready
  function automatic logic [15:0] dev_status();
    if (err_at >= 0 && int'(dev_idx) == err_at) return 16'h0038;
    if (stuck) return {1'b0, dev_idx, 8'h00};
    if (matched) return 16'h0031;
    rd_cnt++;
    if (rd_cnt >= 3) begin
      matched = 1;
      return {1'b0, dev_idx + 7'd1, 8'h00};
    end
    return {1'b0, dev_idx, 8'h00};
  endfunction

  task automatic tick();
    logic [18:0] exp_w;
    @(negedge clk);
    reg_ack = 1'b0; reg_nack = 1'b0; smp_valid = 1'b0; start = 1'b0; err_clear = 1'b0;
    if (reset) begin
      in_flight = 0;
      smp_hi = 0;
      return;
    end
    if (done) done_cnt++;
    // sample source
    if (smp_req) begin
      smp_cycles++;
      smp_hi++;
      if (reg_req) bus_in_fetch++;
      if (smp_hi == ((fetch_n == stall_idx) ? 21 : 1)) begin
        smp_valid = 1'b1;
        smp_data  = sample_of(fetch_n);
        fetch_n++;
      end
    end else if (smp_hi != 0) begin
      if (fetch_n - 1 == stall_idx) stall_run = smp_hi;
      smp_hi = 0;
    end
    // register device
    if (reg_req && !in_flight) begin
      in_flight = 1; lat = 2;
      cur_we = reg_we; cur_addr = reg_addr; cur_wdata = reg_wdata;
      if (reg_we) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write", reg_addr, reg_wdata);
        end else begin
          exp_w = sb_q.pop_front();
          if ({reg_addr, reg_wdata} !== exp_w) begin
            errors++;
            $display("FAIL write_seq: got addr=%0d data=%h expected addr=%0d data=%h",
                     reg_addr, reg_wdata, exp_w[18:16], exp_w[15:0]);
          end
        end
        if (reg_addr == A_MCU && reg_wdata[7:0] == 8'h03) begin
          dev_idx = reg_wdata[14:8]; rd_cnt = 0; matched = 0;
        end
      end
    end else if (in_flight) begin
      if (!reg_req) in_flight = 0;
      else begin
        lat--;
        if (lat == 0) begin
          in_flight = 0;
          if (nack_en && cur_we && cur_addr == A_MCU && cur_wdata == 16'h0001) reg_nack = 1'b1;
          else reg_ack = 1'b1;
          if (!cur_we) begin
            if (cur_addr == A_ASIC) begin
              asic_reads++;
              reg_rdata = dev_status();
            end else reg_rdata = RESULT;
          end
        end
      end
    end
  endtask

  task automatic push_run(input int last, input bit full);
    sb_q.push_back({A_MCU, 16'h0001});
    for (int i = 0; i <= last; i++) begin
      sb_q.push_back({A_SMP, sample_of(i)});
      sb_q.push_back({A_MCU, {1'b0, 7'(i), 8'h03}});
    end
    if (full) begin
      sb_q.push_back({A_MCU, 16'h0004});
      sb_q.push_back({A_MCU, 16'h0000});
    end
  endtask

  task automatic clear_counters();
    asic_reads = 0; fetch_n = 0; smp_cycles = 0; bus_in_fetch = 0;
    done_cnt = 0; stall_run = 0; smp_hi = 0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (state_o == s) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if ({reg_req, reg_we, smp_req, busy, done, error} !== 6'b0) begin errors++;
      $display("FAIL reset_flags: got %b expected 000000", {reg_req, reg_we, smp_req, busy, done, error}); end
    checks++; if ({reg_addr, reg_wdata, tone, err_code} !== 37'h0) begin errors++;
      $display("FAIL reset_values: got %h expected 0", {reg_addr, reg_wdata, tone, err_code}); end
  endtask

  task automatic test_nominal();
    bit ok;
    clear_counters();
    push_run(127, 1);
    start = 1'b1; tick();
    wait_done(12000, ok);
    repeat (3) tick();
    checks++; if (!ok) begin errors++; $display("FAIL nom_done_timeout: got no done expected done"); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL nom_done_count: got %0d expected 1", done_cnt); end
    checks++; if (tone !== RESULT) begin errors++; $display("FAIL nom_tone: got %h expected %h", tone, RESULT); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL nom_writes_left: got %0d expected 0", sb_q.size()); end
    checks++; if (asic_reads !== 385) begin errors++; $display("FAIL nom_status_reads: got %0d expected 385", asic_reads); end
    checks++; if (fetch_n !== 128) begin errors++; $display("FAIL nom_samples: got %0d expected 128", fetch_n); end
    checks++; if ({state_o, busy} !== 5'b0) begin errors++; $display("FAIL nom_idle: got %b expected 0", {state_o, busy}); end
    sb_q.delete();
  endtask

  task automatic test_escape();
    bit ok;
    sb_q.push_back({A_MCU, 16'h0010});
    sb_q.push_back({A_MCU, 16'h0000});
    err_clear = 1'b1; tick();
    wait_state(4'd0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL esc_idle: got state %0d expected 0", state_o); end
    checks++; if ({error, err_code} !== 3'b0) begin errors++; $display("FAIL esc_clear: got %b expected 000", {error, err_code}); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL esc_writes_left: got %0d expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_nack();
    bit ok;
    clear_counters();
    nack_en = 1;
    push_run(-1, 0);
    start = 1'b1; tick();
    wait_state(4'd10, 200, ok);
    nack_en = 0;
    checks++; if (!ok) begin errors++; $display("FAIL nack_err_state: got %0d expected 10", state_o); end
    checks++; if ({error, err_code} !== 3'b111) begin errors++; $display("FAIL nack_code: got %b expected 111", {error, err_code}); end
    checks++; if (smp_cycles !== 0) begin errors++; $display("FAIL nack_no_sample: got %0d expected 0", smp_cycles); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy: got %b expected 0", busy); end
    test_escape();
  endtask

  task automatic test_dev_error();
    bit ok;
    clear_counters();
    err_at = 5;
    push_run(5, 0);
    start = 1'b1; tick();
    wait_state(4'd10, 3000, ok);
    err_at = -1;
    checks++; if (!ok) begin errors++; $display("FAIL deverr_state: got %0d expected 10", state_o); end
    checks++; if ({error, err_code} !== 3'b110) begin errors++; $display("FAIL deverr_code: got %b expected 110", {error, err_code}); end
    checks++; if (fetch_n !== 6) begin errors++; $display("FAIL deverr_samples: got %0d expected 6", fetch_n); end
    test_escape();
  endtask

  task automatic test_timeout();
    bit ok;
    clear_counters();
    stuck = 1;
    push_run(0, 0);
    start = 1'b1; tick();
    wait_state(4'd10, 500, ok);
    stuck = 0;
    checks++; if (!ok) begin errors++; $display("FAIL tmo_state: got %0d expected 10", state_o); end
    checks++; if (asic_reads !== 4) begin errors++; $display("FAIL tmo_reads: got %0d expected 4", asic_reads); end
    checks++; if ({error, err_code} !== 3'b101) begin errors++; $display("FAIL tmo_code: got %b expected 101", {error, err_code}); end
    test_escape();
  endtask

  task automatic test_stall();
    bit ok;
    clear_counters();
    stall_idx = 64;
    push_run(127, 1);
    start = 1'b1; tick();
    ok = 0;
    for (int i = 0; i < 12000; i++) begin
      if (done_cnt > 0) begin ok = 1; break; end
      if (fetch_n == 64 && smp_hi == 5) start = 1'b1;  // must be ignored while busy
      tick();
    end
    repeat (3) tick();
    stall_idx = -1;
    checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout: got no done expected done"); end
    checks++; if (stall_run !== 21) begin errors++; $display("FAIL stall_req_len: got %0d expected 21", stall_run); end
    checks++; if (smp_cycles !== 148) begin errors++; $display("FAIL stall_req_total: got %0d expected 148", smp_cycles); end
    checks++; if (bus_in_fetch !== 0) begin errors++; $display("FAIL stall_bus_quiet: got %0d expected 0", bus_in_fetch); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL stall_writes_left: got %0d expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_counters();
    push_run(30, 0);
    start = 1'b1; tick();
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (state_o == 4'd5 && dev_idx == 7'd30) begin ok = 1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_reach: got state %0d idx %0d expected 5/30", state_o, dev_idx); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if ({state_o, reg_req, reg_we, smp_req, busy, done, error} !== 10'b0) begin errors++;
      $display("FAIL rst_mid_flags: got %b expected 0", {state_o, reg_req, reg_we, smp_req, busy, done, error}); end
    checks++; if ({reg_addr, reg_wdata, tone, err_code} !== 37'h0) begin errors++;
      $display("FAIL rst_mid_values: got %h expected 0", {reg_addr, reg_wdata, tone, err_code}); end
    repeat (4) tick();
    checks++; if (reg_req !== 1'b0) begin errors++; $display("FAIL rst_mid_no_req: got %b expected 0", reg_req); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL rst_mid_writes_left: got %0d expected 0", sb_q.size()); end
    sb_q.delete();
    test_nominal();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_nack();
    test_dev_error();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
